instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_if.sv | 25 ++
 rtl/instr_fetch.sv | 79 +++++++
 tb/tb_instr_fetch.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-unit bundle: program load port, CPU-controller requests, fetched instruction.
// master = CPU/loader side, slave = instr_fetch.
interface instr_fetch_if;
   logic        start;
   logic        load_en;
   logic [4:0]  load_addr;
   logic [22:0] load_data;
   logic        inc_pc;
   logic        branch;
   logic [4:0]  branch_addr;
   logic [22:0] code;
   logic [4:0]  pc;
   logic        valid;
   logic        halted;

   modport master (
      output start, load_en, load_addr, load_data, inc_pc, branch, branch_addr,
      input  code, pc, valid, halted
   );

   modport slave (
      input  start, load_en, load_addr, load_data, inc_pc, branch, branch_addr,
      output code, pc, valid, halted
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch with 32x23 program memory; request-to-valid latency 2 cycles (FETCH, HOLD).
// No backpressure: code is held in HOLD until inc_pc/branch; requests outside HOLD are dropped.
module instr_fetch (
   input  logic          clk,
   input  logic          rst,
   instr_fetch_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;

   localparam logic [2:0] OP_HALT = 3'b111;

   state_t      state;
   logic [4:0]  pc;
   logic [22:0] ir;
   logic        valid;
   logic        halted;
   logic [22:0] mem [32];
   logic        load_ok;

   assign load_ok = bus.load_en && ((state == IDLE) || (state == HALT));

   // No reset on the array: program survives rst, but a write is never taken while rst is high.
   always_ff @(posedge clk) begin
      if (!rst && load_ok)
         mem[bus.load_addr] <= bus.load_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         pc     <= 5'd0;
         ir     <= 23'd0;
         valid  <= 1'b0;
         halted <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start && !bus.load_en)
                  state <= FETCH;
            end
            FETCH: begin
               ir    <= mem[pc];
               valid <= 1'b1;
               state <= HOLD;
            end
            HOLD: begin
               // HALT opcode takes priority over any pending controller request.
               if (ir[22:20] == OP_HALT) begin
                  valid  <= 1'b0;
                  halted <= 1'b1;
                  state  <= HALT;
               end else if (bus.branch) begin
                  pc    <= bus.branch_addr;
                  valid <= 1'b0;
                  state <= FETCH;
               end else if (bus.inc_pc) begin
                  pc    <= pc + 5'd1;
                  valid <= 1'b0;
                  state <= FETCH;
               end
            end
            HALT: begin
               if (bus.start && !bus.load_en) begin
                  pc     <= 5'd0;
                  halted <= 1'b0;
                  state  <= FETCH;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // code mirrors the instruction register: zero after reset, last word while halted.
   assign bus.code   = ir;
   assign bus.pc     = pc;
   assign bus.valid  = valid;
   assign bus.halted = halted;
endmodule

// File: tb/tb_instr_fetch.sv
// Directed vector bench for instr_fetch: table of per-cycle stimulus/expectations plus
// hand sequences for HALT-mode loads and asynchronous reset.
module tb_instr_fetch;
   localparam bit N = 1'b0;
   localparam bit Y = 1'b1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;

   instr_fetch_if bus();

   instr_fetch dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit        start;
      bit        load_en;
      bit [4:0]  load_addr;
      bit [22:0] load_data;
      bit        inc_pc;
      bit        branch;
      bit [4:0]  branch_addr;
      bit [22:0] e_code;
      bit [4:0]  e_pc;
      bit        e_valid;
      bit        e_halted;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input bit st, input bit le, input bit [4:0] la, input bit [22:0] ld,
                               input bit inc, input bit br, input bit [4:0] ba,
                               input bit [22:0] ec, input bit [4:0] ep, input bit ev, input bit eh);
      vec_t v;
      v.start = st; v.load_en = le; v.load_addr = la; v.load_data = ld;
      v.inc_pc = inc; v.branch = br; v.branch_addr = ba;
      v.e_code = ec; v.e_pc = ep; v.e_valid = ev; v.e_halted = eh;
      vecs.push_back(v);
   endfunction

   task automatic drive(input bit st, input bit le, input bit [4:0] la, input bit [22:0] ld,
                        input bit inc, input bit br, input bit [4:0] ba);
      bus.start = st; bus.load_en = le; bus.load_addr = la; bus.load_data = ld;
      bus.inc_pc = inc; bus.branch = br; bus.branch_addr = ba;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input bit st, input bit le, input bit [4:0] la, input bit [22:0] ld,
                       input bit inc, input bit br, input bit [4:0] ba);
      drive(st, le, la, ld, inc, br, ba);
      tick();
   endtask

   task automatic check(input string nm, input bit [22:0] ec, input bit [4:0] ep, input bit ev, input bit eh);
      n_checks++;
      if ({bus.code, bus.pc, bus.valid, bus.halted} !== {ec, ep, ev, eh}) begin
         n_fail++;
         $display("FAIL %s: got code=%h pc=%0d valid=%b halted=%b, expected code=%h pc=%0d valid=%b halted=%b",
                  nm, bus.code, bus.pc, bus.valid, bus.halted, ec, ep, ev, eh);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      drive(N, N, 5'd0, 23'h0, N, N, 5'd0);
      tick();
      tick();
      check("reset_state", 23'h0, 5'd0, N, N);
      rst = 1'b0;

      // Program load in IDLE; outputs stay at reset values.
      add(N, Y, 5'd0,  23'h100001, N, N, 5'd0,  23'h0, 5'd0, N, N);
      add(N, Y, 5'd1,  23'h200002, N, N, 5'd0,  23'h0, 5'd0, N, N);
      add(N, Y, 5'd2,  23'h700000, N, N, 5'd0,  23'h0, 5'd0, N, N);
      add(N, Y, 5'd3,  23'h033333, N, N, 5'd0,  23'h0, 5'd0, N, N);
      add(N, Y, 5'd5,  23'h055555, N, N, 5'd0,  23'h0, 5'd0, N, N);
      add(N, Y, 5'd9,  23'h099999, N, N, 5'd0,  23'h0, 5'd0, N, N);
      add(N, Y, 5'd17, 23'h011111, N, N, 5'd0,  23'h0, 5'd0, N, N);
      add(N, Y, 5'd31, 23'h031031, N, N, 5'd0,  23'h0, 5'd0, N, N);
      add(Y, Y, 5'd18, 23'h012222, N, N, 5'd0,  23'h0, 5'd0, N, N);
      add(N, N, 5'd0,  23'h0,      Y, Y, 5'd7,  23'h0, 5'd0, N, N);
      // Start -> FETCH -> HOLD at pc 0, then inc to pc 1.
      add(Y, N, 5'd0, 23'h0, N, N, 5'd0,  23'h0,      5'd0,  N, N);
      add(N, N, 5'd0, 23'h0, N, N, 5'd0,  23'h100001, 5'd0,  Y, N);
      add(N, N, 5'd0, 23'h0, N, N, 5'd0,  23'h100001, 5'd0,  Y, N);
      add(N, N, 5'd0, 23'h0, Y, N, 5'd0,  23'h100001, 5'd1,  N, N);
      add(N, N, 5'd0, 23'h0, N, N, 5'd0,  23'h200002, 5'd1,  Y, N);
      // Branch to 3, ignored HOLD-time load, branch beats inc to 17.
      add(N, N, 5'd0, 23'h0,      N, Y, 5'd3,  23'h200002, 5'd3,  N, N);
      add(N, N, 5'd0, 23'h0,      N, N, 5'd0,  23'h033333, 5'd3,  Y, N);
      add(N, Y, 5'd5, 23'h2ABCDE, N, N, 5'd0,  23'h033333, 5'd3,  Y, N);
      add(N, N, 5'd0, 23'h0,      Y, Y, 5'd17, 23'h033333, 5'd17, N, N);
      add(N, N, 5'd0, 23'h0,      N, N, 5'd0,  23'h011111, 5'd17, Y, N);
      add(N, N, 5'd0, 23'h0,      N, Y, 5'd5,  23'h011111, 5'd5,  N, N);
      add(N, N, 5'd0, 23'h0,      N, N, 5'd0,  23'h055555, 5'd5,  Y, N);
      // pc 31 wraps to 0; requests during FETCH are dropped.
      add(N, N, 5'd0, 23'h0, N, Y, 5'd31, 23'h055555, 5'd31, N, N);
      add(N, N, 5'd0, 23'h0, Y, Y, 5'd9,  23'h031031, 5'd31, Y, N);
      add(N, N, 5'd0, 23'h0, Y, N, 5'd0,  23'h031031, 5'd0,  N, N);
      add(N, N, 5'd0, 23'h0, N, N, 5'd0,  23'h100001, 5'd0,  Y, N);
      add(N, N, 5'd0, 23'h0, Y, N, 5'd0,  23'h100001, 5'd1,  N, N);
      add(N, N, 5'd0, 23'h0, N, N, 5'd0,  23'h200002, 5'd1,  Y, N);
      add(N, N, 5'd0, 23'h0, Y, N, 5'd0,  23'h200002, 5'd2,  N, N);
      add(N, N, 5'd0, 23'h0, N, N, 5'd0,  23'h700000, 5'd2,  Y, N);
      // HALT wins over requests, inc ignored while halted, start restarts at pc 0.
      add(N, N, 5'd0, 23'h0, Y, Y, 5'd4,  23'h700000, 5'd2,  N, Y);
      add(N, N, 5'd0, 23'h0, Y, N, 5'd0,  23'h700000, 5'd2,  N, Y);
      add(Y, N, 5'd0, 23'h0, N, N, 5'd0,  23'h700000, 5'd0,  N, N);
      add(N, N, 5'd0, 23'h0, N, N, 5'd0,  23'h100001, 5'd0,  Y, N);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].start, vecs[i].load_en, vecs[i].load_addr, vecs[i].load_data,
              vecs[i].inc_pc, vecs[i].branch, vecs[i].branch_addr);
         check($sformatf("vec%0d", i), vecs[i].e_code, vecs[i].e_pc, vecs[i].e_valid, vecs[i].e_halted);
      end

      // Loads made while halted are visible to later fetches.
      step(N, N, 5'd0, 23'h0, N, Y, 5'd2);         check("halt2_fetch", 23'h100001, 5'd2, N, N);
      step(N, N, 5'd0, 23'h0, N, N, 5'd0);         check("halt2_hold",  23'h700000, 5'd2, Y, N);
      step(N, N, 5'd0, 23'h0, N, N, 5'd0);         check("halt2_enter", 23'h700000, 5'd2, N, Y);
      step(Y, Y, 5'd0, 23'h0AAAAA, N, N, 5'd0);    check("halt_start_load", 23'h700000, 5'd2, N, Y);
      step(N, Y, 5'd2, 23'h022222, N, N, 5'd0);    check("halt_load_pc", 23'h700000, 5'd2, N, Y);
      step(Y, N, 5'd0, 23'h0, N, N, 5'd0);         check("restart_fetch", 23'h700000, 5'd0, N, N);
      step(N, N, 5'd0, 23'h0, N, N, 5'd0);         check("restart_new0", 23'h0AAAAA, 5'd0, Y, N);
      step(N, N, 5'd0, 23'h0, Y, N, 5'd0);         check("inc_fetch1", 23'h0AAAAA, 5'd1, N, N);
      step(N, N, 5'd0, 23'h0, N, N, 5'd0);         check("hold1", 23'h200002, 5'd1, Y, N);
      step(N, N, 5'd0, 23'h0, Y, N, 5'd0);         check("inc_fetch2", 23'h200002, 5'd2, N, N);
      step(N, N, 5'd0, 23'h0, N, N, 5'd0);         check("new2_visible", 23'h022222, 5'd2, Y, N);

      // Asynchronous reset between edges while in HOLD at pc 9.
      step(N, N, 5'd0, 23'h0, N, Y, 5'd9);         check("br9_fetch", 23'h022222, 5'd9, N, N);
      step(N, N, 5'd0, 23'h0, N, N, 5'd0);         check("br9_hold", 23'h099999, 5'd9, Y, N);
      #3;
      drive(N, Y, 5'd9, 23'h7FFFFF, N, N, 5'd0);
      rst = 1'b1;
      #1;
      check("async_rst", 23'h0, 5'd0, N, N);
      tick();
      check("rst_held", 23'h0, 5'd0, N, N);
      drive(N, N, 5'd0, 23'h0, N, N, 5'd0);
      rst = 1'b0;
      step(N, N, 5'd0, 23'h0, N, N, 5'd0);         check("post_rst_idle", 23'h0, 5'd0, N, N);
      step(Y, N, 5'd0, 23'h0, N, N, 5'd0);         check("rerun_fetch", 23'h0, 5'd0, N, N);
      step(N, N, 5'd0, 23'h0, N, N, 5'd0);         check("rerun_mem0", 23'h0AAAAA, 5'd0, Y, N);
      step(N, N, 5'd0, 23'h0, N, Y, 5'd9);         check("rerun_br9", 23'h0AAAAA, 5'd9, N, N);
      step(N, N, 5'd0, 23'h0, N, N, 5'd0);         check("mem9_kept", 23'h099999, 5'd9, Y, N);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
